icu_sequencer: RTL

- Program sequencer that drives the ICU instruction input from a program memory.
- Holds the program counter, decodes JMP/RTN/NOPF itself, and keeps a small return-address stack so that JMP acts as a subroutine call and RTN as its return.
- Provides run/stop/single-step control.
- Skip behaviour (SKZ, post-RTN skip) is not handled here; it remains inside the ICU.

---
 rtl/icu_sequencer_pkg.sv | 33 +++
 rtl/icu_sequencer_return_stack.sv | 59 +++++
 rtl/icu_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/icu_sequencer_pkg.sv
// Shared definitions for the ICU program sequencer.
//   OPCODE_W      : width of an ICU opcode
//   instruction_t : ICU instruction set (4-bit opcodes)
//   seq_state_t   : sequencer control state (IDLE / RUN)
package icu_sequencer_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/icu_sequencer_return_stack.sv
// Return-address LIFO for the ICU sequencer.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous flush (occupancy back to zero)
//   push, pop  : never asserted together; ignored when full / empty
//   push_data  : return address to store
//   top_data   : most recently pushed address (valid when !empty)
//   full/empty : occupancy == DEPTH / occupancy == 0
//   sp         : current occupancy
module icu_sequencer_return_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    output logic [AW-1:0]                top_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   sp
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] count;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  wr_idx;

    assign full    = (count == SPW'(DEPTH));
    assign empty   = (count == '0);
    assign sp      = count;
    assign wr_idx  = IW'(count);
    assign top_idx = IW'(count - SPW'(1));
    assign top_data = mem[top_idx];

    // Storage has no reset: contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + SPW'(1);
        end else if (pop && !empty) begin
            count <= count - SPW'(1);
        end
    end

endmodule

// File: rtl/icu_sequencer.sv
// Program sequencer feeding the ICU instruction input from a program memory.
// Holds the PC, handles JMP (call) / RTN (return) / NOPF (optional halt)
// itself, and offers run / stop / single-step control.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : reload PC with RESET_VECTOR, flush stack and error, run
//   cont       : run from the current PC
//   stop       : back to IDLE, PC held (wins over start/cont)
//   step       : in IDLE, execute one instruction
//   prog_addr  : program memory address (= PC)
//   prog_word  : {opcode, jump target} read combinationally at prog_addr
//   icu_i      : instruction presented to the ICU (NOPO when not executing)
//   running    : high in RUN
//   stack_err  : sticky stack overflow / underflow
//   sp         : return stack occupancy
module icu_sequencer
    import icu_sequencer_pkg::*;
#(
    parameter int            AW           = 8,
    parameter int            DEPTH        = 4,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter bit            HALT_ON_NOPF = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cont,
    input  logic                         stop,
    input  logic                         step,
    output logic [AW-1:0]                prog_addr,
    input  logic [OPCODE_W+AW-1:0]       prog_word,
    output instruction_t                 icu_i,
    output logic                         running,
    output logic                         stack_err,
    output logic [$clog2(DEPTH+1)-1:0]   sp
);

    seq_state_t   state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] tgt;
    logic [AW-1:0] top_data;
    instruction_t opcode;
    logic         err;
    logic         exec;
    logic         do_start;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;

    assign opcode   = instruction_t'(prog_word[OPCODE_W+AW-1:AW]);
    assign tgt      = prog_word[AW-1:0];
    assign pc_inc   = pc + AW'(1);

    // stop suppresses start entirely, so a start that loses to stop must
    // not reload the PC or flush the stack either.
    assign do_start = start && !stop;

    // The stop cycle in RUN does not execute; a step is only honoured in
    // IDLE when nothing else is requesting a transition.
    assign exec = ((state == RUN) && !stop) ||
                  ((state == IDLE) && step && !start && !cont);

    // A start in RUN overrides the instruction's effect on PC and stack.
    assign push = exec && !do_start && (opcode == JMP) && !full;
    assign pop  = exec && !do_start && (opcode == RTN) && !empty;

    assign icu_i     = exec ? opcode : NOPO;
    assign prog_addr = pc;
    assign running   = (state == RUN);
    assign stack_err = err;

    icu_sequencer_return_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (do_start),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .full      (full),
        .empty     (empty),
        .sp        (sp)
    );

    // Control FSM, PC and sticky error. Overflowing JMP still jumps but
    // loses its return address; underflowing RTN falls through to PC+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stop && (start || cont)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop || (exec && HALT_ON_NOPF && (opcode == NOPF))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_start) begin
                pc  <= RESET_VECTOR;
                err <= 1'b0;
            end else if (exec) begin
                case (opcode)
                    JMP: begin
                        pc <= tgt;
                        if (full) begin
                            err <= 1'b1;
                        end
                    end
                    RTN: begin
                        if (empty) begin
                            pc  <= pc_inc;
                            err <= 1'b1;
                        end else begin
                            pc <= top_data;
                        end
                    end
                    default: pc <= pc_inc;
                endcase
            end
        end
    end

endmodule
